time24_counter: RTL and testbench

- Upstream time source for the 24-hour clock display: keeps hours, minutes and seconds as BCD digit pairs and drives the per-digit 7-segment decoders.
- Provides `DIN` (one BCD digit) and `EN` (blank control) to each decoder instance.
- Two push-button inputs select set mode and step the displayed value.
- The block-driven `EN_HOUR` and `EN_MIN` outputs blink the field being set.

---
 rtl/time24_pkg.sv | 20 ++
 rtl/bcd2_mod_cnt.sv | 62 ++++++
 rtl/time24_counter.sv | 151 +++++++++++++++
 tb/tb_time24_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/time24_pkg.sv
// time24_pkg: shared types and limits for the 24-hour BCD time counter.
`default_nettype none

package time24_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage

`default_nettype wire

// File: rtl/bcd2_mod_cnt.sv
// bcd2_mod_cnt: two-digit BCD counter wrapping MAX -> 00, with synchronous clear.
`default_nettype none

module bcd2_mod_cnt
  import time24_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t ones_o,
  output bcd_t tens_o,
  output logic wrap_o
);

  localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);
  localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);

  bcd_t ones_q, ones_d;
  bcd_t tens_q, tens_d;
  logic at_max;

  assign at_max = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);
  assign wrap_o = inc_i && at_max;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr_i) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc_i) begin
      if (at_max) begin
        ones_d = '0;
        tens_d = '0;
      end else if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;

endmodule

`default_nettype wire

// File: rtl/time24_counter.sv
// time24_counter: HH:MM:SS BCD time source with button set mode and field blinking.
// Optional macro TIME24_SECCLR_EN: leaving minute-set clears seconds and restarts the prescaler.
`default_nettype none

module time24_counter
  import time24_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [3:0] SEC_L,
  output logic [3:0] SEC_H,
  output logic [3:0] MIN_L,
  output logic [3:0] MIN_H,
  output logic [3:0] HOUR_L,
  output logic [3:0] HOUR_H,
  output logic       EN_HOUR,
  output logic       EN_MIN,
  output logic       EN_SEC,
  output logic       SET_MODE
);

  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          phase_q, phase_d;
  logic          half_tick, sec_tick;

  logic          mode_prev_q, up_prev_q;
  logic          mode_ev, up_ev;

  state_e        state_q, state_d;
  logic          en_hour_q, en_hour_d;
  logic          en_min_q, en_min_d;
  logic          set_mode_q, set_mode_d;

  logic          sec_inc, min_inc, hour_inc, sec_clr;
  logic          sec_wrap, min_wrap, hour_wrap_unused;

  assign half_tick = (presc_q == HALF_LAST);
  assign sec_tick  = half_tick & phase_q;

  // Mode takes priority; an UP edge in the same cycle is dropped.
  assign mode_ev = BTN_MODE & ~mode_prev_q;
  assign up_ev   = BTN_UP & ~up_prev_q & ~mode_ev;

`ifdef TIME24_SECCLR_EN
  logic leave_set;
  assign leave_set = (state_q == SET_MIN) & mode_ev;
  assign sec_clr   = leave_set;
`else
  assign sec_clr   = 1'b0;
`endif

  always_comb begin
    presc_d = half_tick ? '0 : presc_q + 1'b1;
    phase_d = phase_q ^ half_tick;
`ifdef TIME24_SECCLR_EN
    if (leave_set) begin
      presc_d = '0;
      phase_d = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    if (mode_ev) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
    // Enables follow the next state so they change on the same edge as the state.
    en_hour_d  = !((state_d == SET_HOUR) && phase_d);
    en_min_d   = !((state_d == SET_MIN) && phase_d);
    set_mode_d = (state_d != RUN);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      presc_q     <= '0;
      phase_q     <= 1'b0;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      state_q     <= RUN;
      en_hour_q   <= 1'b1;
      en_min_q    <= 1'b1;
      set_mode_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      mode_prev_q <= BTN_MODE;
      up_prev_q   <= BTN_UP;
      state_q     <= state_d;
      en_hour_q   <= en_hour_d;
      en_min_q    <= en_min_d;
      set_mode_q  <= set_mode_d;
    end
  end

  // Carries only propagate while running; set-mode steps never ripple upward.
  assign sec_inc  = (state_q == RUN) & sec_tick;
  assign min_inc  = ((state_q == RUN) & sec_wrap) | ((state_q == SET_MIN) & up_ev);
  assign hour_inc = ((state_q == RUN) & min_wrap) | ((state_q == SET_HOUR) & up_ev);

  bcd2_mod_cnt #(.MAX(SEC_MAX)) u_sec (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .inc_i  (sec_inc),
    .clr_i  (sec_clr),
    .ones_o (SEC_L),
    .tens_o (SEC_H),
    .wrap_o (sec_wrap)
  );

  bcd2_mod_cnt #(.MAX(MIN_MAX)) u_min (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .inc_i  (min_inc),
    .clr_i  (1'b0),
    .ones_o (MIN_L),
    .tens_o (MIN_H),
    .wrap_o (min_wrap)
  );

  bcd2_mod_cnt #(.MAX(HOUR_MAX)) u_hour (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .inc_i  (hour_inc),
    .clr_i  (1'b0),
    .ones_o (HOUR_L),
    .tens_o (HOUR_H),
    .wrap_o (hour_wrap_unused)
  );

  assign EN_HOUR  = en_hour_q;
  assign EN_MIN   = en_min_q;
  assign EN_SEC   = 1'b1;
  assign SET_MODE = set_mode_q;

endmodule

`default_nettype wire

// File: tb/tb_time24_counter.sv
// tb_time24_counter: directed, table-driven checks of time24_counter at CLK_HZ=10.
`default_nettype none

module tb_time24_counter;

  localparam int CLK_HZ = 10;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic [3:0] SEC_L, SEC_H, MIN_L, MIN_H, HOUR_L, HOUR_H;
  logic       EN_HOUR, EN_MIN, EN_SEC, SET_MODE;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  int epoch   = 0;

  always #5 CLK = ~CLK;

  time24_counter #(.CLK_HZ(CLK_HZ)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .BTN_MODE (BTN_MODE),
    .BTN_UP   (BTN_UP),
    .SEC_L    (SEC_L),
    .SEC_H    (SEC_H),
    .MIN_L    (MIN_L),
    .MIN_H    (MIN_H),
    .HOUR_L   (HOUR_L),
    .HOUR_H   (HOUR_H),
    .EN_HOUR  (EN_HOUR),
    .EN_MIN   (EN_MIN),
    .EN_SEC   (EN_SEC),
    .SET_MODE (SET_MODE)
  );

  typedef struct {
    string       name;
    bit          mode;
    bit          up;
    int          hold;
    int          reps;
    logic [23:0] exp_time;
    bit          exp_set;
  } vec_t;

  vec_t vecs [0:10];

  function automatic logic [23:0] now_t();
    return {HOUR_H, HOUR_L, MIN_H, MIN_L, SEC_H, SEC_L};
  endfunction

  // Blink phase after a given edge, counted from the last prescaler restart.
  function automatic bit phase_at(input int e);
    return (((e - epoch) / 5) % 2) == 1;
  endfunction

  function automatic int next_tick_edge();
    return epoch + ((edges - epoch) / 10 + 1) * 10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    edges++;
  endtask

  task automatic run_to(input int target);
    while (edges < target) tick();
  endtask

  task automatic apply(input vec_t v);
    for (int r = 0; r < v.reps; r++) begin
      BTN_MODE = v.mode;
      BTN_UP   = v.up;
      repeat (v.hold) tick();
      BTN_MODE = 1'b0;
      BTN_UP   = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [23:0] exp_pre;

    vecs[0]  = '{"hour_plus1",   1'b0, 1'b1, 1,  1,  24'h010100, 1'b1};
    vecs[1]  = '{"hour_plus8",   1'b0, 1'b1, 1,  8,  24'h090100, 1'b1};
    vecs[2]  = '{"hour_09_to_10",1'b0, 1'b1, 1,  1,  24'h100100, 1'b1};
    vecs[3]  = '{"hour_plus13",  1'b0, 1'b1, 1,  13, 24'h230100, 1'b1};
    vecs[4]  = '{"hour_23_to_00",1'b0, 1'b1, 1,  1,  24'h000100, 1'b1};
    vecs[5]  = '{"hour_plus23",  1'b0, 1'b1, 1,  23, 24'h230100, 1'b1};
    vecs[6]  = '{"mode_up_same", 1'b1, 1'b1, 1,  1,  24'h230100, 1'b1};
    vecs[7]  = '{"up_held_50",   1'b0, 1'b1, 50, 1,  24'h230200, 1'b1};
    vecs[8]  = '{"min_plus57",   1'b0, 1'b1, 1,  57, 24'h235900, 1'b1};
    vecs[9]  = '{"min_59_to_00", 1'b0, 1'b1, 1,  1,  24'h230000, 1'b1};
    vecs[10] = '{"min_plus59",   1'b0, 1'b1, 1,  59, 24'h235900, 1'b1};

    nRST = 1'b0;
    BTN_MODE = 1'b0;
    BTN_UP = 1'b0;
    tick();
    tick();
    chk("rst_time", now_t(), 24'h000000);
    chk("rst_en", {EN_HOUR, EN_MIN, EN_SEC}, 3'b111);
    chk("rst_setmode", SET_MODE, 1'b0);

    nRST = 1'b1;
    edges = 0;
    epoch = 0;
    run_to(37);
    chk("run37_time", now_t(), 24'h000003);

    // Asynchronous reset asserted at the falling edge, mid-cycle.
    #4;
    nRST = 1'b0;
    #1;
    chk("async_rst_time", now_t(), 24'h000000);
    chk("async_rst_en", {EN_HOUR, EN_MIN, EN_SEC}, 3'b111);
    chk("async_rst_setmode", SET_MODE, 1'b0);
    tick();
    chk("rst_held_time", now_t(), 24'h000000);
    nRST = 1'b1;
    edges = 0;
    epoch = 0;

    run_to(9);
    chk("sec_before_first", now_t(), 24'h000000);
    tick();
    chk("sec_first", now_t(), 24'h000001);
    run_to(590);
    chk("sec_59", now_t(), 24'h000059);
    run_to(599);
    chk("sec_59_hold", now_t(), 24'h000059);
    tick();
    chk("min_carry", now_t(), 24'h000100);

    BTN_MODE = 1'b1;
    tick();
    BTN_MODE = 1'b0;
    chk("enter_set_hour", SET_MODE, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("blink_en_hour", EN_HOUR, !phase_at(edges));
      chk("blink_en_min", EN_MIN, 1'b1);
      tick();
    end
    chk("sec_frozen", now_t(), 24'h000100);

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i]);
      chk(vecs[i].name, now_t(), vecs[i].exp_time);
      chk({vecs[i].name, "_set"}, SET_MODE, vecs[i].exp_set);
    end

    for (int i = 0; i < 10; i++) begin
      chk("min_blink_en_min", EN_MIN, !phase_at(edges));
      chk("min_blink_en_hour", EN_HOUR, 1'b1);
      tick();
    end

    // Leave SET_MIN at 23:59:00 and let a full minute elapse.
    BTN_MODE = 1'b1;
    tick();
`ifdef TIME24_SECCLR_EN
    epoch = edges;
`endif
    BTN_MODE = 1'b0;
    chk("leave_set_mode", SET_MODE, 1'b0);
    chk("leave_time", now_t(), 24'h235900);
    chk("leave_en_min", EN_MIN, 1'b1);
    n = next_tick_edge();
    run_to(n + 589);
    chk("midnight_pre", now_t(), 24'h235959);
    tick();
    chk("midnight_wrap", now_t(), 24'h000000);

    run_to(edges + 420);
    chk("sec_42", now_t(), 24'h000042);
    for (int m = 0; m < 3; m++) begin
      BTN_MODE = 1'b1;
      tick();
      BTN_MODE = 1'b0;
      if (m < 2) tick();
    end
`ifdef TIME24_SECCLR_EN
    epoch = edges;
    exp_pre = 24'h000000;
`else
    exp_pre = 24'h000042;
`endif
    chk("exit_setmode", SET_MODE, 1'b0);
    chk("exit_time", now_t(), exp_pre);
    n = next_tick_edge();
    run_to(n - 1);
    chk("resume_pre", now_t(), exp_pre);
    tick();
    chk("resume_tick", now_t(), exp_pre + 24'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
